// File: rtl/board_top_sys.sv
// -----------------------------------------------------------------------------
// board_top_sys -- FPGA board top: pipelined MIPS core plus an 8-digit
// multiplexed seven-segment display showing one CPU register in hex.
//
// Ports:
//   clk    in   system clock shared by the CPU and the display scanner
//   rst    in   synchronous active-high reset
//   ena    in   CPU run enable (0 freezes the CPU; the display keeps scanning)
//   o_seg  out  active-low segments, bit0=a .. bit6=g, bit7=dp (always off)
//   o_sel  out  active-low digit anodes, bit i = digit i, digit 0 rightmost
//
// Also in this file: the small MIPS core (mips_cpu), its decode stage
// (pipe_id) and register file (regfile), plus their shared types.
// -----------------------------------------------------------------------------

package board_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLL
  } alu_op_e;

  // Decode -> execute pipeline register. All-zero is a bubble (we = 0).
  typedef struct packed {
    alu_op_e     alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        we;
  } id_ex_t;

  // Execute -> memory -> writeback pipeline registers.
  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        we;
  } wb_t;
endpackage

// -----------------------------------------------------------------------------
// regfile -- 32 x 32 register file, $0 hard-wired to zero.
//   Two operand read ports with write-through so an instruction in decode
//   sees a value being written back in the same cycle; one combinational
//   debug read port (no write-through, it shows the stored value).
// -----------------------------------------------------------------------------
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  logic [31:0] array_reg [32];
  logic        wr_live;

  // NOTE: this array is reset explicitly because the core architecturally
  // starts with all registers at zero; a plain RAM would not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) array_reg[i] <= '0;
    end else if (wr_live) begin
      array_reg[waddr] <= wdata;
    end
  end

  // Entry 0 is never written, so it reads back as zero forever.
  assign wr_live  = we && (waddr != 5'd0);
  assign rdata_a  = (wr_live && waddr == raddr_a) ? wdata : array_reg[raddr_a];
  assign rdata_b  = (wr_live && waddr == raddr_b) ? wdata : array_reg[raddr_b];
  assign dbg_data = array_reg[dbg_addr];
endmodule

// -----------------------------------------------------------------------------
// pipe_id -- decode stage: field split, operand read, immediate handling and
// jump resolution. Jumps resolve here, so the fetch slot behind a jump is the
// architectural delay slot and no flush is needed.
// Supported: sll addu subu and or | addiu andi ori lui | j. Others are nops.
// -----------------------------------------------------------------------------
module pipe_id
  import board_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] instr,
  input  logic [3:0]  pc_hi,
  input  wb_t         wb,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output id_ex_t      id_out,
  output logic        jump,
  output logic [31:0] jump_target
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  // Writeback is gated by ena so a frozen core cannot change its registers.
  regfile regfile_inst (
    .clk      (clk),
    .rst      (rst),
    .we       (wb.we & ena),
    .waddr    (wb.dest),
    .wdata    (wb.result),
    .raddr_a  (rs),
    .rdata_a  (rs_val),
    .raddr_b  (rt),
    .rdata_b  (rt_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    id_out       = '0;
    id_out.a     = rs_val;
    id_out.b     = rt_val;
    id_out.shamt = instr[10:6];
    id_out.dest  = rd;
    jump         = 1'b0;
    case (opcode)
      6'h00: begin
        id_out.we = 1'b1;
        case (funct)
          6'h00:   id_out.alu_op = ALU_SLL;
          6'h21:   id_out.alu_op = ALU_ADD;
          6'h23:   id_out.alu_op = ALU_SUB;
          6'h24:   id_out.alu_op = ALU_AND;
          6'h25:   id_out.alu_op = ALU_OR;
          default: id_out.we     = 1'b0;
        endcase
      end
      6'h02: jump = 1'b1;
      6'h09: begin  // addiu
        id_out.alu_op = ALU_ADD;
        id_out.b      = {{16{imm[15]}}, imm};
        id_out.dest   = rt;
        id_out.we     = 1'b1;
      end
      6'h0C: begin  // andi
        id_out.alu_op = ALU_AND;
        id_out.b      = {16'h0000, imm};
        id_out.dest   = rt;
        id_out.we     = 1'b1;
      end
      6'h0D: begin  // ori
        id_out.alu_op = ALU_OR;
        id_out.b      = {16'h0000, imm};
        id_out.dest   = rt;
        id_out.we     = 1'b1;
      end
      6'h0F: begin  // lui: 0 | (imm << 16)
        id_out.alu_op = ALU_OR;
        id_out.a      = '0;
        id_out.b      = {imm, 16'h0000};
        id_out.dest   = rt;
        id_out.we     = 1'b1;
      end
      default: ;
    endcase
  end

  // pc_hi comes from the fetch pc, i.e. the delay-slot address.
  assign jump_target = {pc_hi, instr[25:0], 2'b00};
endmodule

// -----------------------------------------------------------------------------
// mips_cpu -- five-stage pipeline IF/ID/EX/MEM/WB with a built-in program ROM.
// No forwarding network: the program keeps two slots between dependent
// instructions and the register-file write-through covers the rest.
// Debug visibility: pc (fetch address), instr (instruction in decode).
// -----------------------------------------------------------------------------
module mips_cpu
  import board_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] fetch_word;
  logic        jump;
  logic [31:0] jump_target;
  id_ex_t      id_dec;
  id_ex_t      id_ex;
  wb_t         ex_res;
  wb_t         ex_mem;
  wb_t         mem_wb;

  // Demo program; unlisted words are nop (sll $0,$0,0).
  always_comb begin
    case (pc[7:2])
      6'd0:    fetch_word = 32'h3C02_1234;  // lui   $2, 0x1234
      6'd3:    fetch_word = 32'h3442_5678;  // ori   $2, $2, 0x5678
      6'd40:   fetch_word = 32'h3C02_ABCD;  // lui   $2, 0xABCD
      6'd43:   fetch_word = 32'h3442_EF09;  // ori   $2, $2, 0xEF09
      6'd44:   fetch_word = 32'h2400_0055;  // addiu $0, $0, 0x55 (discarded)
      6'd45:   fetch_word = 32'h0810_002D;  // j     0x004000B4 (spin here)
      default: fetch_word = 32'h0000_0000;
    endcase
  end

  pipe_id pipe_id_inst (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .instr       (instr),
    .pc_hi       (pc[31:28]),
    .wb          (mem_wb),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .id_out      (id_dec),
    .jump        (jump),
    .jump_target (jump_target)
  );

  always_comb begin
    ex_res      = '0;
    ex_res.dest = id_ex.dest;
    ex_res.we   = id_ex.we;
    case (id_ex.alu_op)
      ALU_ADD: ex_res.result = id_ex.a + id_ex.b;
      ALU_SUB: ex_res.result = id_ex.a - id_ex.b;
      ALU_AND: ex_res.result = id_ex.a & id_ex.b;
      ALU_OR:  ex_res.result = id_ex.a | id_ex.b;
      ALU_SLL: ex_res.result = id_ex.b << id_ex.shamt;
      default: ex_res.result = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value, whatever the statement order.
  // rst is checked before ena so reset always wins over a frozen core.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      instr  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (ena) begin
      pc     <= jump ? jump_target : pc + 32'd4;
      instr  <= fetch_word;
      id_ex  <= id_dec;
      ex_mem <= ex_res;
      mem_wb <= ex_mem;  // no data memory: MEM is a plain pass-through stage
    end
  end
endmodule

// -----------------------------------------------------------------------------
// board_top_sys -- see file header. SCAN_DIV must be at least 3.
// -----------------------------------------------------------------------------
module board_top_sys #(
  parameter int SCAN_DIV = 17,
  parameter int DISP_REG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic [7:0] o_seg,
  output logic [7:0] o_sel
);
  logic [31:0]         dbg_data;
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [2:0]          idx;
  logic [3:0]          nibble;
  logic [7:0]          seg_next;

  mips_cpu cpu_inst (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .dbg_addr (5'(DISP_REG)),
    .dbg_data (dbg_data)
  );

  // Top three counter bits pick the digit; the lower bits set the dwell time.
  assign idx    = scan_cnt[SCAN_DIV-1 -: 3];
  assign nibble = dbg_data[{idx, 2'b00} +: 4];

  // Active-low hex font, dp (bit 7) kept dark.
  always_comb begin
    case (nibble)
      4'h0:    seg_next = 8'hC0;
      4'h1:    seg_next = 8'hF9;
      4'h2:    seg_next = 8'hA4;
      4'h3:    seg_next = 8'hB0;
      4'h4:    seg_next = 8'h99;
      4'h5:    seg_next = 8'h92;
      4'h6:    seg_next = 8'h82;
      4'h7:    seg_next = 8'hF8;
      4'h8:    seg_next = 8'h80;
      4'h9:    seg_next = 8'h90;
      4'hA:    seg_next = 8'h88;
      4'hB:    seg_next = 8'h83;
      4'hC:    seg_next = 8'hC6;
      4'hD:    seg_next = 8'hA1;
      4'hE:    seg_next = 8'h86;
      default: seg_next = 8'h8E;
    endcase
  end

  // Registered pins: one clk from counter/register value to the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      o_seg    <= 8'hFF;
      o_sel    <= 8'hFF;
    end else begin
      scan_cnt <= scan_cnt + SCAN_DIV'(1);
      o_seg    <= seg_next;
      o_sel    <= ~(8'h01 << idx);
    end
  end
endmodule

// File: tb/tb_board_top_sys.sv
// -----------------------------------------------------------------------------
// tb_board_top_sys -- directed bench for board_top_sys.
// Two instances share clk/rst/ena: dut_a shows $2, dut_b shows $0. Both use
// SCAN_DIV=4, so each digit is lit for two cycles and a full scan is 16.
// -----------------------------------------------------------------------------
module tb_board_top_sys;
  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] seg_a;
  logic [7:0] sel_a;
  logic [7:0] seg_b;
  logic [7:0] sel_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] pc_hold;
  logic [31:0] instr_hold;
  logic [31:0] regs_hold [32];

  localparam logic [7:0] SEL_TAB  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  localparam logic [7:0] SEG_1234 [8] = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
  localparam logic [7:0] SEG_ABCD [8] = '{8'h90, 8'hC0, 8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88};
  localparam logic [7:0] SEG_ZERO [8] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

  board_top_sys #(.SCAN_DIV(4), .DISP_REG(2)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .o_seg (seg_a),
    .o_sel (sel_a)
  );

  board_top_sys #(.SCAN_DIV(4), .DISP_REG(0)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .o_seg (seg_b),
    .o_sel (sel_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] cur_sel(input bit use_b);
    return use_b ? sel_b : sel_a;
  endfunction

  function automatic logic [7:0] cur_seg(input bit use_b);
    return use_b ? seg_b : seg_a;
  endfunction

  function automatic logic [31:0] reg_a(input int i);
    return dut_a.cpu_inst.pipe_id_inst.regfile_inst.array_reg[i];
  endfunction

  // Align to the first cycle of digit 0, then check one full scan and the wrap.
  task automatic scan_check(input string name, input bit use_b, input logic [7:0] segs [8]);
    int budget;
    budget = 0;
    while (cur_sel(use_b) !== 8'h7F && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_align7f"}, cur_sel(use_b), 8'h7F);
    budget = 0;
    while (cur_sel(use_b) !== 8'hFE && budget < 4) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_alignfe"}, cur_sel(use_b), 8'hFE);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_sel%0d", name, i), cur_sel(use_b), SEL_TAB[i/2]);
      check($sformatf("%s_seg%0d", name, i), cur_seg(use_b), segs[i/2]);
      @(negedge clk);
    end
    check({name, "_wrap_sel"}, cur_sel(use_b), 8'hFE);
    check({name, "_wrap_seg"}, cur_seg(use_b), segs[0]);
  endtask

  initial begin
    int budget;

    // Reset held for two edges.
    rst = 1'b1;
    ena = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_sel_a", sel_a, 8'hFF);
    check("rst_seg_a", seg_a, 8'hFF);
    check("rst_sel_b", sel_b, 8'hFF);
    check("rst_seg_b", seg_b, 8'hFF);
    check("rst_pc", dut_a.cpu_inst.pc, 32'h0040_0000);
    check("rst_instr", dut_a.cpu_inst.instr, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("rst_reg%0d", i), reg_a(i), 32'h0);

    // First edge after release: digit 0 of value 0.
    rst = 1'b0;
    @(negedge clk);
    check("rel_sel", sel_a, 8'hFE);
    check("rel_seg", seg_a, 8'hC0);
    check("rel_pc", dut_a.cpu_inst.pc, 32'h0040_0004);

    // Program builds 0x12345678 in $2; freeze the core there.
    budget = 0;
    while (reg_a(2) !== 32'h1234_5678 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("wait_1234", reg_a(2), 32'h1234_5678);
    ena        = 1'b0;
    pc_hold    = dut_a.cpu_inst.pc;
    instr_hold = dut_a.cpu_inst.instr;
    for (int i = 0; i < 32; i++) regs_hold[i] = reg_a(i);

    // The display keeps rotating while the core is frozen.
    scan_check("d1234", 1'b0, SEG_1234);
    check("frz_pc", dut_a.cpu_inst.pc, pc_hold);
    check("frz_instr", dut_a.cpu_inst.instr, instr_hold);
    for (int i = 0; i < 32; i++) check($sformatf("frz_reg%0d", i), reg_a(i), regs_hold[i]);

    // Resume from the same pc.
    ena = 1'b1;
    @(negedge clk);
    check("resume_pc", dut_a.cpu_inst.pc, pc_hold + 32'd4);

    // Second value with hex letters.
    budget = 0;
    while (reg_a(2) !== 32'hABCD_EF09 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("wait_abcd", reg_a(2), 32'hABCD_EF09);
    scan_check("dabcd", 1'b0, SEG_ABCD);

    // $0 was targeted by addiu but must stay zero; dut_b shows all zeros.
    check("reg0_zero", reg_a(0), 32'h0);
    scan_check("dreg0", 1'b1, SEG_ZERO);

    // Reset mid-scan at digit 5, with ena low to show rst has priority.
    budget = 0;
    while (sel_a !== 8'hDF && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("mid_align", sel_a, 8'hDF);
    rst = 1'b1;
    ena = 1'b0;
    @(negedge clk);
    check("mid_sel", sel_a, 8'hFF);
    check("mid_seg", seg_a, 8'hFF);
    check("mid_pc", dut_a.cpu_inst.pc, 32'h0040_0000);
    check("mid_instr", dut_a.cpu_inst.instr, 32'h0);
    check("mid_reg2", reg_a(2), 32'h0);
    rst = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    check("mid_rel_sel", sel_a, 8'hFE);
    check("mid_rel_seg", seg_a, 8'hC0);
    @(negedge clk);
    check("mid_rel_sel2", sel_a, 8'hFE);
    @(negedge clk);
    check("mid_rel_sel3", sel_a, 8'hFD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
